// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared Gauss-Seidel sizing, state encodings and helpers
package gsim_pkg;
    localparam int N_VAR = 16;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int IDX_W = $clog2(N_VAR);

    typedef enum logic [1:0] {CIDLE, CAPT, CDROP} cap_state_t;
    typedef enum logic       {DIDLE, DRAIN}       drn_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/gsim_q_conv.sv
// rtl/gsim_q_conv.sv - combinational Q16.16 to Q8.8 round-half-up and saturate
module gsim_q_conv import gsim_pkg::*; (
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] q,
    output logic             sat
);
    localparam logic signed [IN_W:0] RND     = (IN_W+1)'(1 << (SHIFT-1));
    localparam logic signed [IN_W:0] MAX_POS = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] MIN_NEG = ~MAX_POS;

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] t;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign sum = $signed({x[IN_W-1], x}) + RND;
    assign t   = sum >>> SHIFT;

    always_comb begin
        q   = t[OUT_W-1:0];
        sat = 1'b0;
        if (t > MAX_POS) begin
            q   = {1'b0, {(OUT_W-1){1'b1}}};
            sat = 1'b1;
        end else if (t < MIN_NEG) begin
            q   = {1'b1, {(OUT_W-1){1'b0}}};
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/gsim_out_buf.sv
// rtl/gsim_out_buf.sv - ping-pong capture of solver frames with Q8.8 drain stream
module gsim_out_buf import gsim_pkg::*; (
    input  logic             clk,
    input  logic             reset,
    input  logic             sol_valid,
    input  logic [IN_W-1:0]  sol_x,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [OUT_W-1:0] o_data,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_sat,
    output logic [7:0]       drop_cnt,
    output logic             busy
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VAR - 1);

    logic             cap_en, cap_prev;
    cap_state_t       cst;
    drn_state_t       dst;
    logic [IDX_W-1:0] wr_idx, rd_idx, wr_addr, nxt_idx;
    logic             wr_bank, last_wr, rd_bank, oldest;
    logic [1:0]       full;
    logic [OUT_W:0]   mem [2][N_VAR];

    logic [OUT_W-1:0] conv_q;
    logic             conv_sat;
    logic             cap_rise, wr_fire, wr_sel, new_bank, dsel, cap_done, drn_free;

    gsim_q_conv u_conv (.x(sol_x), .q(conv_q), .sat(conv_sat));

    assign cap_rise = cap_en && !cap_prev && (cst == CIDLE);
    assign new_bank = (full == 2'b00) ? ~last_wr : full[0];
    assign wr_fire  = (cap_rise && full != 2'b11) || (cst == CAPT && cap_en);
    assign wr_sel   = cap_rise ? new_bank : wr_bank;
    assign wr_addr  = cap_rise ? '0 : wr_idx;
    assign cap_done = (cst == CAPT) && cap_en && (wr_idx == LAST_IDX);
    assign drn_free = (dst == DRAIN) && o_valid && o_ready && o_last;
    assign dsel     = (full == 2'b11) ? oldest : full[1];
    assign nxt_idx  = rd_idx + 1'b1;
    assign busy     = (cst != CIDLE) || (dst != DIDLE) || (|full);

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_sel][wr_addr] <= {conv_sat, conv_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_en   <= 1'b0;
            cap_prev <= 1'b0;
        end else begin
            cap_en   <= sol_valid;
            cap_prev <= cap_en;
        end
    end

    // Capture completion and drain release always hit different banks, so both apply.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full   <= 2'b00;
            oldest <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (cap_done && wr_bank == b[0])
                    full[b] <= 1'b1;
                else if (drn_free && rd_bank == b[0])
                    full[b] <= 1'b0;
            end
            if (drn_free)
                oldest <= ~rd_bank;
            else if (cap_done && !full[~wr_bank])
                oldest <= wr_bank;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cst      <= CIDLE;
            wr_idx   <= '0;
            wr_bank  <= 1'b0;
            last_wr  <= 1'b1;
            drop_cnt <= 8'd0;
        end else begin
            case (cst)
                CIDLE: if (cap_rise) begin
                    wr_idx <= IDX_W'(1);
                    if (full != 2'b11) begin
                        cst     <= CAPT;
                        wr_bank <= new_bank;
                    end else begin
                        cst <= CDROP;
                    end
                end
                CAPT: if (!cap_en) begin
                    cst      <= CIDLE;
                    wr_idx   <= '0;
                    drop_cnt <= sat_inc8(drop_cnt);
                end else if (wr_idx == LAST_IDX) begin
                    cst     <= CIDLE;
                    wr_idx  <= '0;
                    last_wr <= wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
                CDROP: if (!cap_en || wr_idx == LAST_IDX) begin
                    cst      <= CIDLE;
                    wr_idx   <= '0;
                    drop_cnt <= sat_inc8(drop_cnt);
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
                default: cst <= CIDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst     <= DIDLE;
            rd_bank <= 1'b0;
            rd_idx  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            case (dst)
                DIDLE: if (|full) begin
                    dst     <= DRAIN;
                    rd_bank <= dsel;
                    rd_idx  <= '0;
                end
                DRAIN: if (!o_valid) begin
                    o_valid         <= 1'b1;
                    {o_sat, o_data} <= mem[rd_bank][rd_idx];
                    o_idx           <= rd_idx;
                    o_last          <= (rd_idx == LAST_IDX);
                end else if (o_ready) begin
                    if (o_last) begin
                        // One bubble cycle before moving on to the other bank.
                        o_valid <= 1'b0;
                        if (full[~rd_bank]) begin
                            rd_bank <= ~rd_bank;
                            rd_idx  <= '0;
                        end else begin
                            dst <= DIDLE;
                        end
                    end else begin
                        rd_idx          <= nxt_idx;
                        {o_sat, o_data} <= mem[rd_bank][nxt_idx];
                        o_idx           <= nxt_idx;
                        o_last          <= (nxt_idx == LAST_IDX);
                    end
                end
                default: dst <= DIDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gsim_out_buf.sv
// tb/tb_gsim_out_buf.sv - randomized self-checking bench for gsim_out_buf
module tb_gsim_out_buf;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sol_valid = 1'b0;
    logic [31:0] sol_x = '0;
    logic        o_valid, o_ready, o_last, o_sat, busy;
    logic [15:0] o_data;
    logic [3:0]  o_idx;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int exp_drop = 0;
    int words_seen = 0;
    int rdy_mode = 0;
    logic [31:0] frame [16];
    logic [21:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [21:0] prev_word = '0;

    gsim_out_buf dut (
        .clk(clk), .reset(reset), .sol_valid(sol_valid), .sol_x(sol_x),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_idx(o_idx),
        .o_last(o_last), .o_sat(o_sat), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: exact floor((x + 128) / 256), then clamp to the Q8.8 range.
    function automatic logic [16:0] ref_conv(input logic [31:0] x);
        longint r, q;
        r = longint'($signed(x)) + 128;
        q = (r >= 0) ? r / 256 : -((-r + 255) / 256);
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    function automatic void push_frame();
        logic [16:0] c;
        for (int k = 0; k < 16; k++) begin
            c = ref_conv(frame[k]);
            exp_q.push_back({c[16], (k == 15), 4'(k), c[15:0]});
        end
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 32'h00FF_FFFF);
            2: return -$urandom_range(0, 32'h00FF_FFFF);
            default: return {24'h0, 8'($urandom_range(0, 255))};
        endcase
    endfunction

    initial begin
        o_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: o_ready = 1'b0;
                1: o_ready = 1'b1;
                2: o_ready = ~o_ready;
                default: o_ready = $urandom_range(0, 1);
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall)
                check("hold", {9'h0, o_valid, o_sat, o_last, o_idx, o_data}, {9'h0, 1'b1, prev_word});
            if (o_valid && o_ready) begin
                words_seen++;
                if (exp_q.size() == 0)
                    check("extra_word", {10'h0, o_sat, o_last, o_idx, o_data}, 32'hFFFF_FFFF);
                else
                    check("word", {10'h0, o_sat, o_last, o_idx, o_data}, {10'h0, exp_q.pop_front()});
            end
            prev_stall = o_valid && !o_ready;
            prev_word  = {o_sat, o_last, o_idx, o_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_frame(input int n, input int gap);
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            sol_valid = (k < n);
            sol_x = (k > 0) ? frame[k-1] : $urandom;
        end
        repeat (gap) begin
            @(posedge clk); #1;
            sol_x = $urandom;
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) check("timeout", 0, 1);
        check("drop_cnt", drop_cnt, exp_drop);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_idx", o_idx, 0);
        check("rst_last", o_last, 0);
        check("rst_sat", o_sat, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        rdy_mode = 1;
        for (int k = 0; k < 16; k++) frame[k] = 32'(k) << 16;
        push_frame();
        send_frame(16, 2);
        wait_idle();
        check("basic_words", words_seen, 16);

        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        frame[0] = 32'h0000_0080; frame[1] = 32'h0000_007F; frame[2] = 32'hFFFF_FF80;
        frame[3] = 32'h7FFF_0000; frame[4] = 32'h8000_0000;
        push_frame();
        send_frame(16, 2);
        wait_idle();

        rdy_mode = 2;
        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        push_frame();
        send_frame(16, 2);
        wait_idle();

        rdy_mode = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) frame[k] = rand_word();
            if (f < 2) push_frame();
            send_frame(16, 2);
        end
        exp_drop++;
        repeat (4) @(negedge clk);
        check("ovf_drop", drop_cnt, exp_drop);
        check("ovf_busy", busy, 1);
        check("ovf_valid", o_valid, 1);
        check("ovf_idx", o_idx, 0);
        rdy_mode = 1;
        wait_idle();

        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        send_frame(7, 3);
        exp_drop++;
        repeat (4) @(negedge clk);
        check("trunc_valid", o_valid, 0);
        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        push_frame();
        send_frame(16, 2);
        wait_idle();

        rdy_mode = 3;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 16; k++) frame[k] = rand_word();
            push_frame();
            send_frame(16, $urandom_range(1, 4));
            if (f % 2 == 1) wait_idle();
        end
        wait_idle();

        rdy_mode = 1;
        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        push_frame();
        send_frame(16, 0);
        begin
            int cyc = 0;
            while (!(o_valid && o_idx == 4'd5) && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            if (cyc >= 200) check("wait_idx5", 0, 1);
        end
        reset = 1'b0;
        #1;
        check("mrst_valid", o_valid, 0);
        check("mrst_data", o_data, 0);
        check("mrst_idx", o_idx, 0);
        check("mrst_last", o_last, 0);
        check("mrst_sat", o_sat, 0);
        check("mrst_busy", busy, 0);
        check("mrst_drop", drop_cnt, 0);
        exp_q.delete();
        exp_drop = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 16; k++) frame[k] = rand_word();
        push_frame();
        send_frame(16, 2);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
